decode_stage: RTL and testbench

//   RV32I decode stage sitting directly upstream of the ALU. Accepts fetched instruction+PC over a

---
 rtl/rv32i_pkg.sv | 120 ++++++++++++
 rtl/decode_stage_skid_buffer.sv | 47 ++++
 rtl/decode_stage.sv | 66 ++++++
 tb/tb_decode_stage.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// RV32I decode definitions shared by the decode stage and the ALU: opcodes, ALU op codes,
// decoded bundle, and the combinational decode function. DECODE_ILLEGAL_EN selects illegal reporting.
package rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_XOR  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SLTI = 4'b1000,
    ALU_SLT  = 4'b1001,
    ALU_SLTU = 4'b1011,
    ALU_MUL  = 4'b1100,
    ALU_DIV  = 4'b1101
  } alu_op_e;

  // Branch compares reuse the low ALU codes; is_branch tells the ALU which meaning applies.
  localparam alu_op_e ALU_BEQ = ALU_ADD;
  localparam alu_op_e ALU_BNE = ALU_SUB;
  localparam alu_op_e ALU_BLT = ALU_XOR;
  localparam alu_op_e ALU_BGE = ALU_OR;

  typedef struct packed {
    logic                  is_lui;
    logic                  is_i_type;
    logic                  is_branch;
    alu_op_e               alu_ops;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  rd_we;
    logic [XLEN-1:0]       pc;
    logic                  illegal;
  } decoded_t;

  function automatic decoded_t decode(input logic [XLEN-1:0] instr, input logic [XLEN-1:0] pc);
    decoded_t d;
    logic     bad;
    d    = '0;
    d.pc = pc;
    bad  = 1'b0;
    case (instr[6:0])
      OPC_LUI: begin
        d.is_lui  = 1'b1;
        d.imm     = {12'b0, instr[31:12]};
        d.rd_addr = instr[11:7];
        d.alu_ops = ALU_ADD;
      end
      OPC_OP_IMM: begin
        d.is_i_type = 1'b1;
        d.imm       = {{20{instr[31]}}, instr[31:20]};
        d.rs1_addr  = instr[19:15];
        d.rd_addr   = instr[11:7];
        case (instr[14:12])
          3'b000:  d.alu_ops = ALU_ADD;
          3'b100:  d.alu_ops = ALU_XOR;
          3'b010:  d.alu_ops = ALU_SLTI;
          3'b011:  d.alu_ops = ALU_SLTU;
          default: bad = 1'b1;
        endcase
      end
      OPC_OP: begin
        d.rs1_addr = instr[19:15];
        d.rs2_addr = instr[24:20];
        d.rd_addr  = instr[11:7];
        case ({instr[31:25], instr[14:12]})
          {7'b0000000, 3'b000}: d.alu_ops = ALU_ADD;
          {7'b0000000, 3'b100}: d.alu_ops = ALU_XOR;
          {7'b0000000, 3'b110}: d.alu_ops = ALU_OR;
          {7'b0000000, 3'b111}: d.alu_ops = ALU_AND;
          {7'b0000000, 3'b001}: d.alu_ops = ALU_SLL;
          {7'b0000000, 3'b101}: d.alu_ops = ALU_SRL;
          {7'b0000000, 3'b010}: d.alu_ops = ALU_SLT;
          {7'b0100000, 3'b000}: d.alu_ops = ALU_SUB;
          {7'b0000001, 3'b000}: d.alu_ops = ALU_MUL;
          {7'b0000001, 3'b100}: d.alu_ops = ALU_DIV;
          default:              bad = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        d.is_branch = 1'b1;
        d.imm       = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        d.rs1_addr  = instr[19:15];
        d.rs2_addr  = instr[24:20];
        case (instr[14:12])
          3'b000:  d.alu_ops = ALU_BEQ;
          3'b001:  d.alu_ops = ALU_BNE;
          3'b100:  d.alu_ops = ALU_BLT;
          3'b101:  d.alu_ops = ALU_BGE;
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      d    = '0;
      d.pc = pc;
`ifdef DECODE_ILLEGAL_EN
      d.illegal = 1'b1;
`else
      d.is_i_type = 1'b1;
`endif
    end
    d.rd_we = !d.is_branch && !bad && (d.rd_addr != '0);
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_skid_buffer.sv
// Two-entry valid/ready pipeline register (output reg + skid reg) with flush.
// in_ready is the registered "skid empty" flag, so upstream never sees a combinational path.
module skid_buffer #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic skid_valid;
  T     skid_data;

  assign in_ready = !skid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      // Output reg is free this edge: drain the skid first to keep order.
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid && !skid_valid) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes instr/pc_in and hands the bundle to execute through a skid buffer.
// DECODE_ILLEGAL_EN adds the illegal output; otherwise illegal encodings become a NOP.
module decode_stage
  import rv32i_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       instr,
  input  logic [XLEN-1:0]       pc_in,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  is_lui,
  output logic                  is_i_type,
  output logic                  is_branch,
  output logic [3:0]            alu_ops,
  output logic [XLEN-1:0]       imm,
  output logic [REG_ADDR_W-1:0] rs1_addr,
  output logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  rd_we,
  output logic [XLEN-1:0]       pc_data
`ifdef DECODE_ILLEGAL_EN
  ,
  output logic                  illegal
`endif
);

  decoded_t dec;
  decoded_t q;

  always_comb dec = decode(instr, pc_in);

  skid_buffer #(.T(decoded_t)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (q)
  );

  assign is_lui    = q.is_lui;
  assign is_i_type = q.is_i_type;
  assign is_branch = q.is_branch;
  assign alu_ops   = q.alu_ops;
  assign imm       = q.imm;
  assign rs1_addr  = q.rs1_addr;
  assign rs2_addr  = q.rs2_addr;
  assign rd_addr   = q.rd_addr;
  assign rd_we     = q.rd_we;
  assign pc_data   = q.pc;

`ifdef DECODE_ILLEGAL_EN
  assign illegal = q.illegal;
`else
  logic unused_illegal;
  assign unused_illegal = q.illegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode vector table plus skid/flush sequences.
// Build with or without DECODE_ILLEGAL_EN; illegal-row expectations follow the macro.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr, pc_in, imm, pc_data;
  logic        is_lui, is_i_type, is_branch, rd_we;
  logic [3:0]  alu_ops;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
`ifdef DECODE_ILLEGAL_EN
  logic        illegal;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_in(pc_in), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .is_lui(is_lui), .is_i_type(is_i_type),
    .is_branch(is_branch), .alu_ops(alu_ops), .imm(imm), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .rd_addr(rd_addr), .rd_we(rd_we), .pc_data(pc_data)
`ifdef DECODE_ILLEGAL_EN
    , .illegal(illegal)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        lui, ity, br;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        we;
    logic        bad;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic [31:0] i, logic [31:0] p, logic l, logic t, logic b,
                              logic [3:0] a, logic [31:0] m, logic [4:0] s1, logic [4:0] s2,
                              logic [4:0] d, logic w, logic bad);
    vec_t v;
    v.instr = i; v.pc = p; v.lui = l; v.ity = t; v.br = b; v.alu = a; v.imm = m;
    v.rs1 = s1; v.rs2 = s2; v.rd = d; v.we = w; v.bad = bad;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] bundle();
    return {41'b0, is_lui, is_i_type, is_branch, alu_ops, imm, rs1_addr, rs2_addr, rd_addr,
            rd_we, pc_data};
  endfunction

  logic [31:0] got[8];
  int          n;
  logic        fire_in, fire_out;
  logic [127:0] exp_b;

  initial begin
    vecs[0]  = mk(32'h002081B3, 32'h1000, 0, 0, 0, 4'h0, 32'h0,        1, 2,  3, 1, 0);
    vecs[1]  = mk(32'hFFF00093, 32'h1004, 0, 1, 0, 4'h0, 32'hFFFFFFFF, 0, 0,  1, 1, 0);
    vecs[2]  = mk(32'h123452B7, 32'h1008, 1, 0, 0, 4'h0, 32'h00012345, 0, 0,  5, 1, 0);
    vecs[3]  = mk(32'hFE208CE3, 32'h0100, 0, 0, 1, 4'h0, 32'hFFFFFFF8, 1, 2,  0, 0, 0);
    vecs[4]  = mk(32'h0050C213, 32'h1010, 0, 1, 0, 4'h2, 32'h5,        1, 0,  4, 1, 0);
    vecs[5]  = mk(32'h407302B3, 32'h1014, 0, 0, 0, 4'h1, 32'h0,        6, 7,  5, 1, 0);
    vecs[6]  = mk(32'h02A48433, 32'h1018, 0, 0, 0, 4'hC, 32'h0,        9, 10, 8, 1, 0);
    vecs[7]  = mk(32'hFFF1B113, 32'h101C, 0, 1, 0, 4'hB, 32'hFFFFFFFF, 3, 0,  2, 1, 0);
    vecs[8]  = mk(32'h00419863, 32'h1020, 0, 0, 1, 4'h1, 32'h10,       3, 4,  0, 0, 0);
    vecs[9]  = mk(32'h00208033, 32'h1024, 0, 0, 0, 4'h0, 32'h0,        1, 2,  0, 0, 0);
    vecs[10] = mk(32'h0020E333, 32'h1028, 0, 0, 0, 4'h3, 32'h0,        1, 2,  6, 1, 0);
    vecs[11] = mk(32'h00000073, 32'h102C, 0, 0, 0, 4'h0, 32'h0,        0, 0,  0, 0, 1);
    vecs[12] = mk(32'h0010E093, 32'h1030, 0, 0, 0, 4'h0, 32'h0,        0, 0,  0, 0, 1);

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    instr = 32'h0; pc_in = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", {127'b0, out_valid}, 128'd0);
    check("reset_in_ready", {127'b0, in_ready}, 128'd1);
    check("reset_bundle", bundle(), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: one instr per pass, always-ready consumer, check 1 cycle later.
    for (int i = 0; i < 13; i++) begin
      instr = vecs[i].instr; pc_in = vecs[i].pc; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      if (vecs[i].bad) begin
`ifdef DECODE_ILLEGAL_EN
        exp_b = {41'b0, 3'b000, 4'h0, 32'h0, 15'h0, 1'b0, vecs[i].pc};
`else
        exp_b = {41'b0, 3'b010, 4'h0, 32'h0, 15'h0, 1'b0, vecs[i].pc};
`endif
      end else begin
        exp_b = {41'b0, vecs[i].lui, vecs[i].ity, vecs[i].br, vecs[i].alu, vecs[i].imm,
                 vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].we, vecs[i].pc};
      end
      check($sformatf("vec%0d_valid", i), {127'b0, out_valid}, 128'd1);
      check($sformatf("vec%0d_bundle", i), bundle(), exp_b);
`ifdef DECODE_ILLEGAL_EN
      check($sformatf("vec%0d_illegal", i), {127'b0, illegal}, {127'b0, vecs[i].bad});
`endif
    end
    @(negedge clk);
    check("idle_out_valid", {127'b0, out_valid}, 128'd0);

    // Backpressure: 3 instrs offered across 4 stalled cycles, only 2 fit.
    out_ready = 1'b0; in_valid = 1'b1;
    instr = 32'h002081B3; pc_in = 32'h200;
    @(negedge clk);
    instr = 32'h0050C213; pc_in = 32'h204;
    @(negedge clk);
    check("skid_full_in_ready", {127'b0, in_ready}, 128'd0);
    instr = 32'h02A48433; pc_in = 32'h208;
    repeat (2) @(negedge clk);
    check("stall_hold_valid", {127'b0, out_valid}, 128'd1);
    check("stall_hold_pc", {96'b0, pc_data}, {96'b0, 32'h200});
    check("stall_hold_alu", {124'b0, alu_ops}, 128'd0);
    check("stall_in_ready", {127'b0, in_ready}, 128'd0);
    out_ready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      fire_out = out_valid && out_ready;
      fire_in  = in_valid && in_ready;
      if (fire_out && n < 8) begin
        got[n] = pc_data;
        n++;
      end
      @(negedge clk);
      if (fire_in) in_valid = 1'b0;
    end
    check("drain_count", 128'(n), 128'd3);
    check("drain_order0", {96'b0, got[0]}, {96'b0, 32'h200});
    check("drain_order1", {96'b0, got[1]}, {96'b0, 32'h204});
    check("drain_order2", {96'b0, got[2]}, {96'b0, 32'h208});
    check("drain_in_ready", {127'b0, in_ready}, 128'd1);

    // Flush with output and skid full and a new instr offered in the flush cycle.
    out_ready = 1'b0; in_valid = 1'b1;
    instr = 32'h002081B3; pc_in = 32'h300;
    @(negedge clk);
    instr = 32'h0050C213; pc_in = 32'h304;
    @(negedge clk);
    check("pre_flush_in_ready", {127'b0, in_ready}, 128'd0);
    instr = 32'h02A48433; pc_in = 32'h308; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", {127'b0, out_valid}, 128'd0);
    check("flush_in_ready", {127'b0, in_ready}, 128'd1);
    out_ready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (out_valid) n++;
      @(negedge clk);
    end
    check("flush_nothing_emitted", 128'(n), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
